psg_multi: RTL and testbench

PSG_MULTI -- requirements
Module: psg_multi

---
 rtl/psg_pkg.sv | 27 ++
 rtl/psg_env.sv | 61 ++++++
 rtl/psg_multi.sv | 176 +++++++++++++++++
 tb/tb_psg_multi.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared constants for the multi-channel PSG: register offsets, envelope
// states and the 5-bit level to 8-bit amplitude log table.
package psg_pkg;

   typedef enum logic [1:0] {
      RAMP_UP = 2'd0,
      RAMP_DN = 2'd1,
      HOLD    = 2'd2
   } env_st_t;

   localparam logic [2:0] OFF_TLO = 3'd0;
   localparam logic [2:0] OFF_THI = 3'd1;
   localparam logic [2:0] OFF_VOL = 3'd2;
   localparam logic [2:0] OFF_EPL = 3'd3;
   localparam logic [2:0] OFF_EPH = 3'd4;
   localparam logic [2:0] OFF_SHP = 3'd5;
   localparam logic [2:0] OFF_CTL = 3'd6;

   // Strictly increasing so every level step is audible and distinguishable.
   localparam logic [7:0] VOL_TAB [32] = '{
      8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
      8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h13, 8'h16, 8'h1A,
      8'h1E, 8'h23, 8'h29, 8'h30, 8'h38, 8'h41, 8'h4C, 8'h58,
      8'h66, 8'h77, 8'h8A, 8'hA0, 8'hB9, 8'hD6, 8'hEC, 8'hFF
   };

endpackage

// File: rtl/psg_env.sv
// Per-channel envelope generator: 16-bit period counter plus ramp/hold
// state machine producing a 5-bit level.
module psg_env
   import psg_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CE,
   input  logic        TICK,
   input  logic        RESTART,
   input  logic [15:0] PERIOD,
   input  logic [3:0]  SHAPE,
   output logic [4:0]  LEVEL
);

   env_st_t     st;
   logic [15:0] ecnt;
   logic [15:0] lim;
   logic        c_bit, at, alt, h, up, at_end;

   assign {c_bit, at, alt, h} = SHAPE;
   assign lim    = (PERIOD == '0) ? '0 : PERIOD - 16'd1;
   assign up     = (st == RAMP_UP);
   assign at_end = (up && LEVEL == 5'd31) || (st == RAMP_DN && LEVEL == 5'd0);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         st    <= HOLD;
         LEVEL <= 5'd0;
         ecnt  <= '0;
      end else if (CE) begin
         if (RESTART) begin
            ecnt  <= '0;
            LEVEL <= at ? 5'd0 : 5'd31;
            st    <= at ? RAMP_UP : RAMP_DN;
         end else if (TICK) begin
            if (ecnt >= lim) begin
               ecnt <= '0;
               if (st != HOLD) begin
                  if (!at_end)
                     LEVEL <= up ? LEVEL + 5'd1 : LEVEL - 5'd1;
                  else if (!c_bit) begin
                     st    <= HOLD;
                     LEVEL <= 5'd0;
                  end else if (h) begin
                     st    <= HOLD;
                     LEVEL <= (at ^ alt) ? 5'd31 : 5'd0;
                  end else if (alt) begin
                     // turn around without repeating the end level
                     st    <= up ? RAMP_DN : RAMP_UP;
                     LEVEL <= up ? 5'd30 : 5'd1;
                  end else
                     LEVEL <= up ? 5'd0 : 5'd31;
               end
            end else
               ecnt <= ecnt + 16'd1;
         end
      end
   end

endmodule

// File: rtl/psg_multi.sv
// Multi-channel PSG: register file, prescaler, tone and noise generators,
// per-channel envelopes and a registered stereo mixer.
module psg_multi
   import psg_pkg::*;
#(
   parameter  int NCH = 3,
   parameter  int TW  = 12,
   parameter  int DIV = 8,
   localparam int AW  = $clog2(NCH*8+1),
   localparam int OW  = 8 + $clog2(NCH)
)(
   input  logic          CLK,
   input  logic          RESET,
   input  logic          CE,
   input  logic          WE,
   input  logic [AW-1:0] ADDR,
   input  logic [7:0]    DI,
   output logic [7:0]    DO,
   output logic [OW-1:0] OUT_L,
   output logic [OW-1:0] OUT_R
);

   localparam int PW    = $clog2(DIV);
   localparam int GADDR = NCH*8;

   logic [PW-1:0] pcnt;
   logic          ntog, tick, ntick;
   logic [4:0]    nper, ncnt, nlim;
   logic [16:0]   lfsr;
   logic [2:0]    off;
   logic [AW-4:0] ach;

   logic [7:0]    tone_lo [NCH];
   logic [TW-9:0] tone_hi [NCH];
   logic [4:0]    vol_r   [NCH];
   logic [15:0]   eper    [NCH];
   logic [3:0]    shape   [NCH];
   logic [3:0]    ctl     [NCH];
   logic          pend    [NCH];
   logic          tone_b  [NCH];
   logic [4:0]    elvl    [NCH];
   logic [7:0]    mix     [NCH];
   logic [OW-1:0] sum_l, sum_r;

   assign off   = ADDR[2:0];
   assign ach   = ADDR[AW-1:3];
   assign tick  = CE && (pcnt == PW'(DIV-1));
   assign ntick = tick && ntog;
   assign nlim  = (nper == '0) ? '0 : nper - 5'd1;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pcnt <= '0;
         ntog <= 1'b0;
         nper <= '0;
         ncnt <= '0;
         lfsr <= 17'd1;
      end else begin
         if (WE && int'(ADDR) == GADDR) nper <= DI[4:0];
         if (CE) pcnt <= pcnt + 1'b1;
         if (tick) ntog <= ~ntog;
         if (ntick) begin
            if (ncnt >= nlim) begin
               ncnt <= '0;
               // an all-zero LFSR would lock up; reseed instead of shifting
               lfsr <= (lfsr == '0) ? 17'd1 : {lfsr[15:0], lfsr[16] ^ lfsr[13]};
            end else
               ncnt <= ncnt + 5'd1;
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic          we_c, gate;
      logic [TW-1:0] tper, tlim, tcnt;
      logic [4:0]    lvl;

      assign we_c = WE && (int'(ach) == g);
      assign tper = {tone_hi[g], tone_lo[g]};
      assign tlim = (tper == '0) ? '0 : tper - 1'b1;

      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) begin
            tone_lo[g] <= '0;
            tone_hi[g] <= '0;
            vol_r[g]   <= '0;
            eper[g]    <= '0;
            shape[g]   <= '0;
            ctl[g]     <= 4'hC;
            pend[g]    <= 1'b0;
         end else begin
            if (we_c) begin
               case (off)
                  OFF_TLO: tone_lo[g]     <= DI;
                  OFF_THI: tone_hi[g]     <= DI[TW-9:0];
                  OFF_VOL: vol_r[g]       <= DI[4:0];
                  OFF_EPL: eper[g][7:0]   <= DI;
                  OFF_EPH: eper[g][15:8]  <= DI;
                  OFF_SHP: shape[g]       <= DI[3:0];
                  OFF_CTL: ctl[g]         <= DI[3:0];
                  default: ;
               endcase
            end
            // restart request is held until the envelope sees a CE
            pend[g] <= (pend[g] & ~CE) | (we_c && off == OFF_SHP);
         end
      end

      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) begin
            tcnt      <= '0;
            tone_b[g] <= 1'b0;
         end else if (tick) begin
            if (tcnt >= tlim) begin
               tcnt      <= '0;
               tone_b[g] <= ~tone_b[g];
            end else
               tcnt <= tcnt + 1'b1;
         end
      end

      psg_env u_env (
         .CLK     (CLK),
         .RESET   (RESET),
         .CE      (CE),
         .TICK    (tick),
         .RESTART (pend[g]),
         .PERIOD  (eper[g]),
         .SHAPE   (shape[g]),
         .LEVEL   (elvl[g])
      );

      assign gate   = (tone_b[g] | ~ctl[g][0]) & (lfsr[0] | ~ctl[g][1]);
      assign lvl    = !gate ? 5'd0 : vol_r[g][4] ? elvl[g] : {vol_r[g][3:0], vol_r[g][3]};
      assign mix[g] = VOL_TAB[lvl];
   end

   always_comb begin
      sum_l = '0;
      sum_r = '0;
      for (int c = 0; c < NCH; c++) begin
         if (ctl[c][2]) sum_l = sum_l + OW'(mix[c]);
         if (ctl[c][3]) sum_r = sum_r + OW'(mix[c]);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         OUT_L <= '0;
         OUT_R <= '0;
      end else if (CE) begin
         OUT_L <= sum_l;
         OUT_R <= sum_r;
      end
   end

   always_comb begin
      DO = '0;
      if (int'(ADDR) == GADDR) DO = 8'(nper);
      for (int c = 0; c < NCH; c++) begin
         if (int'(ach) == c) begin
            case (off)
               OFF_TLO: DO = tone_lo[c];
               OFF_THI: DO = 8'(tone_hi[c]);
               OFF_VOL: DO = 8'(vol_r[c]);
               OFF_EPL: DO = eper[c][7:0];
               OFF_EPH: DO = eper[c][15:8];
               OFF_SHP: DO = 8'(shape[c]);
               OFF_CTL: DO = 8'(ctl[c]);
               default: DO = '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_psg_multi.sv
// Randomized and directed bench for psg_multi against a behavioural model
// of the register map, generators and mixer.
module tb_psg_multi;

   localparam int NCH = 3;
   localparam int TW  = 12;
   localparam int DIV = 8;
   localparam int AW  = $clog2(NCH*8+1);
   localparam int OW  = 8 + $clog2(NCH);

   logic          CLK = 1'b0, RESET = 1'b0, CE = 1'b0, WE = 1'b0;
   logic [AW-1:0] ADDR = '0;
   logic [7:0]    DI = '0;
   logic [7:0]    DO;
   logic [OW-1:0] OUT_L, OUT_R;

   psg_multi #(.NCH(NCH), .TW(TW), .DIV(DIV)) dut (
      .CLK(CLK), .RESET(RESET), .CE(CE), .WE(WE), .ADDR(ADDR), .DI(DI),
      .DO(DO), .OUT_L(OUT_L), .OUT_R(OUT_R)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0, n_fail = 0;

   task automatic check(string tag, int obs, int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   int TAB [32] = '{
      'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07,
      'h08, 'h0A, 'h0C, 'h0E, 'h10, 'h13, 'h16, 'h1A,
      'h1E, 'h23, 'h29, 'h30, 'h38, 'h41, 'h4C, 'h58,
      'h66, 'h77, 'h8A, 'hA0, 'hB9, 'hD6, 'hEC, 'hFF
   };

   // model state; env mode 0=up 1=down 2=hold
   int m_reg [0:NCH*8];
   int m_pre, m_ntog, m_ncnt, m_lfsr, m_outl, m_outr;
   int m_tcnt [NCH], m_tbit [NCH], m_ecnt [NCH], m_lvl [NCH], m_mode [NCH], m_pend [NCH];

   function automatic int mask_of(int a);
      if (a == NCH*8) return 'h1F;
      case (a % 8)
         0, 3, 4: return 'hFF;
         1:       return (1 << (TW-8)) - 1;
         2:       return 'h1F;
         5, 6:    return 'h0F;
         default: return 0;
      endcase
   endfunction

   function automatic int rd(int a);
      if (a > NCH*8) return 0;
      return m_reg[a];
   endfunction

   function automatic int tri_lvl(int k);
      int p = k % 62;
      return (p <= 31) ? p : 62 - p;
   endfunction

   task automatic m_reset();
      for (int a = 0; a <= NCH*8; a++) m_reg[a] = 0;
      for (int c = 0; c < NCH; c++) begin
         m_reg[c*8+6] = 'h0C;
         m_tcnt[c] = 0; m_tbit[c] = 0; m_ecnt[c] = 0;
         m_lvl[c] = 0; m_mode[c] = 2; m_pend[c] = 0;
      end
      m_pre = 0; m_ntog = 0; m_ncnt = 0; m_lfsr = 1; m_outl = 0; m_outr = 0;
   endtask

   function automatic int m_level(int c);
      int ctl = m_reg[c*8+6];
      int v   = m_reg[c*8+2];
      bit gate = (m_tbit[c] != 0 || (ctl & 1) == 0) && ((m_lfsr & 1) != 0 || (ctl & 2) == 0);
      if (!gate) return 0;
      if (v & 16) return m_lvl[c];
      return (v & 15) * 2 + ((v >> 3) & 1);
   endfunction

   task automatic env_step(int c);
      int s = m_reg[c*8+5];
      bit cb = s[3], at = s[2], alt = s[1], h = s[0];
      if (m_mode[c] == 2) return;
      if (m_mode[c] == 0 && m_lvl[c] < 31) m_lvl[c]++;
      else if (m_mode[c] == 1 && m_lvl[c] > 0) m_lvl[c]--;
      else if (!cb) begin m_mode[c] = 2; m_lvl[c] = 0; end
      else if (h) begin m_mode[c] = 2; m_lvl[c] = (at ^ alt) ? 31 : 0; end
      else if (alt) begin
         if (m_mode[c] == 0) begin m_mode[c] = 1; m_lvl[c] = 30; end
         else begin m_mode[c] = 0; m_lvl[c] = 1; end
      end else m_lvl[c] = (m_mode[c] == 0) ? 0 : 31;
   endtask

   task automatic m_step(bit we, int a, int d, bit ce);
      if (ce) begin
         int sl = 0, sr = 0, per, lim;
         bit tick, nt;
         for (int c = 0; c < NCH; c++) begin
            int lv = TAB[m_level(c)];
            if (m_reg[c*8+6] & 4) sl += lv;
            if (m_reg[c*8+6] & 8) sr += lv;
         end
         m_outl = sl; m_outr = sr;
         tick = (m_pre == DIV-1);
         m_pre = (m_pre + 1) % DIV;
         if (tick) begin
            for (int c = 0; c < NCH; c++) begin
               per = m_reg[c*8] + 256 * m_reg[c*8+1];
               lim = (per > 0) ? per - 1 : 0;
               if (m_tcnt[c] >= lim) begin m_tcnt[c] = 0; m_tbit[c] ^= 1; end
               else m_tcnt[c]++;
            end
            nt = (m_ntog != 0);
            m_ntog ^= 1;
            if (nt) begin
               lim = (m_reg[NCH*8] > 0) ? m_reg[NCH*8] - 1 : 0;
               if (m_ncnt >= lim) begin
                  m_ncnt = 0;
                  if (m_lfsr == 0) m_lfsr = 1;
                  else m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 16) ^ (m_lfsr >> 13)) & 1)) & 'h1FFFF;
               end else m_ncnt++;
            end
         end
         for (int c = 0; c < NCH; c++) begin
            if (m_pend[c] != 0) begin
               m_pend[c] = 0; m_ecnt[c] = 0;
               if (m_reg[c*8+5] & 4) begin m_lvl[c] = 0; m_mode[c] = 0; end
               else begin m_lvl[c] = 31; m_mode[c] = 1; end
            end else if (tick) begin
               per = m_reg[c*8+3] + 256 * m_reg[c*8+4];
               lim = (per > 0) ? per - 1 : 0;
               if (m_ecnt[c] >= lim) begin m_ecnt[c] = 0; env_step(c); end
               else m_ecnt[c]++;
            end
         end
      end
      if (we && a <= NCH*8) begin
         m_reg[a] = d & mask_of(a);
         if (a < NCH*8 && a % 8 == 5) m_pend[a/8] = 1;
      end
   endtask

   task automatic cyc(bit we, int a, int d, bit ce);
      WE = we; ADDR = AW'(a); DI = 8'(d); CE = ce;
      @(negedge CLK);
      check("do", int'(DO), rd(a));
      check("out_l", int'(OUT_L), m_outl);
      check("out_r", int'(OUT_R), m_outr);
      @(posedge CLK);
      m_step(we, a, d, ce);
      #1;
   endtask

   task automatic wr(int a, int d);
      cyc(1'b1, a, d, 1'b1);
   endtask

   task automatic do_reset();
      CE = 1'b0; WE = 1'b0; ADDR = AW'(6);
      RESET = 1'b1;
      #1;
      check("rst_out_l", int'(OUT_L), 0);
      check("rst_out_r", int'(OUT_R), 0);
      check("rst_ctl6", int'(DO), 'h0C);
      check("rst_lfsr", int'(dut.lfsr), 1);
      m_reset();
      @(posedge CLK); #1;
      RESET = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int last, nchg, prev;
      bit seen;
      #1;
      do_reset();

      // single tone channel, P=4: 32-CE half period
      wr(0, 4); wr(1, 0); wr(2, 15); wr(6, 'h0D);
      for (int k = 0; k < 64; k++) cyc(1'b0, 0, 0, 1'b1);
      last = -1; nchg = 0; prev = int'(OUT_L);
      for (int k = 0; k < 300; k++) begin
         cyc(1'b0, 0, 0, 1'b1);
         if (int'(OUT_L) != prev) begin
            if (last >= 0) check("tone_half_period", k - last, 32);
            last = k; prev = int'(OUT_L); nchg++;
         end
      end
      check("tone_toggles", int'(nchg >= 5), 1);

      // triangle envelope, shape 0xE, Pe=1
      do_reset();
      wr(2, 'h10); wr(3, 1); wr(4, 0);
      wr(5, 'hE);
      last = -1; nchg = 0; prev = int'(OUT_L);
      for (int k = 0; k < 600; k++) begin
         cyc(1'b0, 2, 0, 1'b1);
         if (int'(OUT_L) != prev) begin
            nchg++;
            check("env_tri", int'(OUT_L), TAB[tri_lvl(nchg)]);
            if (last >= 0) check("env_step_gap", k - last, 8);
            last = k; prev = int'(OUT_L);
         end
      end
      check("env_tri_steps", int'(nchg >= 70), 1);

      // reset mid-ramp with CE low
      do_reset();

      // shape 0xB: fall to 0, then hold at 31; rewrite restarts at 31
      wr(2, 'h10); wr(3, 1); wr(5, 'hB);
      for (int k = 0; k < 300; k++) cyc(1'b0, 5, 0, 1'b1);
      check("hold31", int'(OUT_L), 'hFF);
      for (int k = 0; k < 200; k++) cyc(1'b0, 5, 0, 1'b1);
      check("hold31_stay", int'(OUT_L), 'hFF);
      wr(5, 'hB);
      seen = 1'b0;
      for (int k = 0; k < 24 && !seen; k++) begin
         cyc(1'b0, 5, 0, 1'b1);
         if (int'(OUT_L) != 'hFF) seen = 1'b1;
      end
      check("restart_found", int'(seen), 1);
      check("restart_next", int'(OUT_L), TAB[30]);

      // stereo pan mix
      do_reset();
      wr(2, 15); wr(10, 15); wr(14, 'h04);
      for (int k = 0; k < 4; k++) cyc(1'b0, 14, 0, 1'b1);
      check("mix_l", int'(OUT_L), 'h1FE);
      check("mix_r", int'(OUT_R), 'h0FF);

      // tone period shrink mid-count
      do_reset();
      wr(0, 'hE8); wr(1, 3); wr(2, 15); wr(6, 'h0D);
      for (int k = 0; k < 6000 && m_tcnt[0] != 500; k++) cyc(1'b0, 0, 0, 1'b1);
      wr(0, 2); wr(1, 0);
      last = -1; nchg = 0; prev = int'(OUT_L);
      for (int k = 0; k < 100; k++) begin
         cyc(1'b0, 1, 0, 1'b1);
         if (int'(OUT_L) != prev) begin
            if (last < 0) check("shrink_first", int'(k <= 9), 1);
            else check("shrink_period", k - last, 16);
            last = k; prev = int'(OUT_L); nchg++;
         end
      end
      check("shrink_toggles", int'(nchg >= 5), 1);

      // random traffic
      do_reset();
      for (int k = 0; k < 3000; k++)
         cyc(($urandom % 4) == 0, int'($urandom_range(0, 31)), int'($urandom % 256), ($urandom % 4) != 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
